// File: rtl/pwm_timer_mc.sv
// pwm_timer_mc: multi-channel PWM/timer with a Wishbone register file.
// Ports: i_clk/i_rst (sync, active-high), Wishbone slave i_wb_*/o_wb_*,
// o_pwm[NUM_CH-1:0] channel outputs, o_irq level interrupt.
module pwm_timer_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [3:0]        i_wb_adr,
  input  logic [31:0]       i_wb_data,
  output logic              o_wb_ack,
  output logic [31:0]       o_wb_data,
  output logic [NUM_CH-1:0] o_pwm,
  output logic              o_irq
);

  logic              en;
  logic              center;
  logic              oneshot;
  logic              os_idle;
  logic [CNT_W-1:0]  prescale;
  logic [CNT_W-1:0]  pre_cnt;
  logic [CNT_W-1:0]  period_sh;
  logic [CNT_W-1:0]  period_act;
  logic [CNT_W-1:0]  cnt;
  logic              dir_dn;
  logic [CNT_W-1:0]  duty_sh  [NUM_CH];
  logic [CNT_W-1:0]  duty_act [NUM_CH];
  logic [1:0]        status;
  logic [1:0]        irq_en;
  logic [NUM_CH-1:0] pol;

  logic              wb_req;
  logic              wr;
  logic              rd;
  logic [1:0]        w1c;
  logic [31:0]       rdata;
  logic              tick;
  logic              pev;
  logic              os_stop;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              dir_nxt;

  logic unused_ok;
  assign unused_ok = ^i_wb_data;

  assign wb_req = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr     = wb_req & i_wb_we;
  assign rd     = wb_req & ~i_wb_we;
  assign w1c    = (wr && i_wb_adr == 4'h3) ? i_wb_data[1:0] : 2'b00;

  always_comb begin
    rdata = '0;
    case (i_wb_adr)
      4'h0: rdata[2:0] = {oneshot, center, en};
      4'h1: rdata[CNT_W-1:0] = prescale;
      4'h2: rdata[CNT_W-1:0] = period_sh;
      4'h3: rdata[1:0] = status;
      4'h4: rdata[1:0] = irq_en;
      4'h5: rdata[NUM_CH-1:0] = pol;
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (i_wb_adr == 4'(8 + i))
            rdata[CNT_W-1:0] = duty_sh[i];
      end
    endcase
  end

  // >= rather than == so a PRESCALE lowered below pre_cnt
  // wraps at once instead of running through the full range.
  assign tick = en && (pre_cnt >= prescale);

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir_dn;
    pev     = 1'b0;
    if (tick) begin
      if (period_act == '0) begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        pev     = 1'b1;
      end else if (!center) begin
        dir_nxt = 1'b0;
        if (cnt >= period_act) begin
          cnt_nxt = '0;
          pev     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end else if (!dir_dn) begin
        if (cnt >= period_act) begin
          // turn around at the top; PERIOD=1 drops straight to 0
          cnt_nxt = period_act - CNT_W'(1);
          if (period_act == CNT_W'(1)) pev = 1'b1;
          else dir_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end else begin
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt = '0;
          dir_nxt = 1'b0;
          pev     = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
    end
  end

  assign os_stop = pev & oneshot;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack   <= 1'b0;
      o_wb_data  <= '0;
      o_pwm      <= '0;
      o_irq      <= 1'b0;
      en         <= 1'b0;
      center     <= 1'b0;
      oneshot    <= 1'b0;
      os_idle    <= 1'b0;
      prescale   <= '0;
      pre_cnt    <= '0;
      period_sh  <= CNT_W'(9);
      period_act <= CNT_W'(9);
      cnt        <= '0;
      dir_dn     <= 1'b0;
      status     <= '0;
      irq_en     <= '0;
      pol        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      o_wb_ack <= i_wb_cyc & i_wb_stb & ~o_wb_ack;
      if (rd) o_wb_data <= rdata;

      if (en) begin
        pre_cnt <= tick ? '0 : pre_cnt + CNT_W'(1);
        cnt     <= cnt_nxt;
        dir_dn  <= dir_nxt;
      end
      if (os_stop) begin
        en      <= 1'b0;
        cnt     <= '0;
        dir_dn  <= 1'b0;
        os_idle <= 1'b1;
      end

      if (!en || pev) begin
        period_act <= period_sh;
        for (int i = 0; i < NUM_CH; i++)
          duty_act[i] <= duty_sh[i];
      end

      // a finished one-shot parks each output at its inactive level
      for (int i = 0; i < NUM_CH; i++) begin
        if (os_idle) o_pwm[i] <= pol[i];
        else if (en) o_pwm[i] <= (cnt < duty_act[i]) ^ pol[i];
      end

      // hardware set wins over a same-edge write-1-to-clear
      status <= (status & ~w1c) | {os_stop, pev};
      o_irq  <= |(status & irq_en);

      if (wr) begin
        case (i_wb_adr)
          4'h0: begin
            en      <= i_wb_data[0];
            center  <= i_wb_data[1];
            oneshot <= i_wb_data[2];
            if (i_wb_data[0]) os_idle <= 1'b0;
            if (!i_wb_data[0] && (i_wb_data[1] != center)) begin
              cnt    <= '0;
              dir_dn <= 1'b0;
            end
          end
          4'h1: prescale  <= i_wb_data[CNT_W-1:0];
          4'h2: period_sh <= i_wb_data[CNT_W-1:0];
          4'h4: irq_en    <= i_wb_data[1:0];
          4'h5: pol       <= i_wb_data[NUM_CH-1:0];
          default: begin
            for (int i = 0; i < NUM_CH; i++)
              if (i_wb_adr == 4'(8 + i))
                duty_sh[i] <= i_wb_data[CNT_W-1:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_timer_mc.sv
// tb_pwm_timer_mc: directed and random checks of pwm_timer_mc
// against a tick-indexed arithmetic model of the PWM waveform.
module tb_pwm_timer_mc;
  localparam int NC = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic          wb_we = 1'b0;
  logic [3:0]    wb_adr = '0;
  logic [31:0]   wb_wdat = '0;
  logic          wb_ack;
  logic [31:0]   wb_rdat;
  logic [NC-1:0] pwm;
  logic          irq;

  pwm_timer_mc #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .i_wb_we(wb_we), .i_wb_adr(wb_adr),
    .i_wb_data(wb_wdat), .o_wb_ack(wb_ack),
    .o_wb_data(wb_rdat), .o_pwm(pwm), .o_irq(irq)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int errors = 0;
  int checks = 0;

  int            m_ps, m_p, m_center;
  logic [NC-1:0] m_pol;
  int            m_old [NC];
  int            m_new [NC];
  longint        m_sw;
  int            m_e0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_acc(input logic we, input logic [3:0] a,
                        input logic [31:0] d, output logic [31:0] q);
    bit got = 0;
    q = '0;
    wb_cyc = 1; wb_stb = 1; wb_we = we;
    wb_adr = a; wb_wdat = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wb_ack) begin
        got = 1;
        q = wb_rdat;
        break;
      end
    end
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    chk("wb_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_acc(1'b1, a, d, q);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] q);
    wb_acc(1'b0, a, 32'd0, q);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic read_all(input string tag);
    logic [31:0] q;
    for (int a = 0; a < 16; a++) begin
      wb_read(4'(a), q);
      chk($sformatf("%s_reg%0d", tag, a), q, (a == 2) ? 32'd9 : 32'd0);
      @(negedge clk);
      chk($sformatf("%s_ack_pulse%0d", tag, a), 32'(wb_ack), 32'd0);
    end
  endtask

  function automatic longint cnt_of(input longint n);
    longint p = m_p;
    longint m;
    if (p == 0) return 0;
    if (m_center == 0) return n % (p + 1);
    m = n % (2 * p);
    return (m <= p) ? m : 2 * p - m;
  endfunction

  function automatic longint plen();
    if (m_p == 0) return 1;
    return (m_center != 0) ? 2 * m_p : m_p + 1;
  endfunction

  task automatic run_chk(input int ncyc, input string tag);
    longint k, n, v;
    logic [NC-1:0] e;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      k = cyc_cnt - m_e0;
      n = (k - 1) / (m_ps + 1);
      v = cnt_of(n);
      for (int i = 0; i < NC; i++)
        e[i] = (v < ((n >= m_sw) ? m_new[i] : m_old[i])) ^ m_pol[i];
      chk(tag, 32'(pwm), 32'(e));
    end
  endtask

  task automatic start(input int ps, input int p, input int c,
                       input int d0, input int d1, input int d2,
                       input int d3, input logic [NC-1:0] pol);
    do_reset();
    m_ps = ps; m_p = p; m_center = c; m_pol = pol;
    m_old[0] = d0; m_old[1] = d1; m_old[2] = d2; m_old[3] = d3;
    m_new = m_old;
    m_sw = 64'h7fff_ffff_ffff;
    wb_write(4'h1, 32'(ps));
    wb_write(4'h2, 32'(p));
    for (int i = 0; i < NC; i++) wb_write(4'(8 + i), 32'(m_old[i]));
    wb_write(4'h5, 32'(pol));
    wb_write(4'h0, 32'(1 + 2 * c));
    m_e0 = cyc_cnt;
  endtask

  // new duty applies from the first period start whose event
  // edge lies strictly after the write edge
  task automatic mid_write(input int ch, input int val);
    longint kw, t, l, nn;
    nn = (cyc_cnt - m_e0 - 1) / (m_ps + 1);
    if (nn >= m_sw) m_old = m_new;
    wb_write(4'(8 + ch), 32'(val));
    kw = cyc_cnt - m_e0;
    t = kw / (m_ps + 1);
    l = plen();
    m_new[ch] = val;
    m_sw = ((t + 1 + l - 1) / l) * l;
  endtask

  initial begin
    logic [31:0] q;
    int ps, p, c, ch;
    logic [NC-1:0] pr;

    do_reset();
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(wb_ack), 32'd0);
    read_all("rst");

    start(0, 9, 0, 3, 0, 0, 0, 4'b0000);
    run_chk(25, "edge");
    mid_write(0, 6);
    run_chk(30, "shadow");
    mid_write(0, 12);
    run_chk(30, "duty_over");
    wb_write(4'h5, 32'd1);
    m_pol = 4'b0001;
    run_chk(15, "pol");

    start(0, 4, 1, 2, 0, 5, 1, 4'b0000);
    run_chk(24, "center");

    for (int r = 0; r < 6; r++) begin
      ps = $urandom_range(0, 3);
      p  = $urandom_range(0, 12);
      c  = $urandom_range(0, 1);
      pr = 4'($urandom);
      start(ps, p, c, $urandom_range(0, p + 2), $urandom_range(0, p + 2),
            $urandom_range(0, p + 2), $urandom_range(0, p + 2), pr);
      run_chk(30, "rand");
      ch = $urandom_range(0, NC - 1);
      mid_write(ch, $urandom_range(0, p + 2));
      run_chk(100, "rand_shadow");
    end

    do_reset();
    wb_write(4'h1, 32'd1);
    wb_write(4'h2, 32'd4);
    wb_write(4'h8, 32'd5);
    wb_write(4'h4, 32'd2);
    wb_write(4'h0, 32'd5);
    m_e0 = cyc_cnt;
    repeat (10) @(negedge clk);
    chk("os_irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    chk("os_irq", 32'(irq), 32'd1);
    chk("os_pwm_idle", 32'(pwm), 32'd0);
    wb_read(4'h0, q);
    chk("os_ctrl", q, 32'd4);
    wb_read(4'h3, q);
    chk("os_status", q, 32'd3);
    wb_write(4'h3, 32'd2);
    chk("w1c_irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    chk("w1c_irq_clr", 32'(irq), 32'd0);

    wb_write(4'h1, 32'd0);
    wb_write(4'h0, 32'd1);
    m_e0 = cyc_cnt;
    repeat (9) @(negedge clk);
    wb_write(4'h3, 32'd1);
    wb_read(4'h3, q);
    chk("pev_set_wins", q, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 5 && ((cyc_cnt - m_e0) % 5) != 1; i++)
      @(negedge clk);
    wb_write(4'h3, 32'd1);
    wb_read(4'h3, q);
    chk("pev_w1c", q, 32'd0);

    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_pwm", 32'(pwm), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    read_all("mid_rst");
    m_ps = 0; m_p = 9; m_center = 0; m_pol = '0;
    m_old[0] = 3; m_old[1] = 0; m_old[2] = 0; m_old[3] = 0;
    m_new = m_old;
    m_sw = 64'h7fff_ffff_ffff;
    wb_write(4'h8, 32'd3);
    wb_write(4'h0, 32'd1);
    m_e0 = cyc_cnt;
    run_chk(20, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
